// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 1:4 TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-4 slot counter with load-to-1 for (re)alignment on a sync slot.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load1,
  output logic [SLOT_W-1:0] count,
  output logic              last
);

  logic [SLOT_W-1:0] cnt_d;
  logic [SLOT_W-1:0] cnt_q;

  // Load wins over increment: the sync slot itself is slot 0, so the next slot is 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load1) begin
      cnt_d = SLOT_W'(1);
    end else if (en) begin
      cnt_d = cnt_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign last  = (cnt_q == SLOT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux_1_4.sv
// 1:4 TDM demultiplexer: hunts for sync, then reassembles four slots per frame.
// Optional misplaced-sync detection and realignment: define TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux_1_4
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sync,
  input  logic [W-1:0]         din,
  output logic [NUM_SLOTS*W-1:0] Y,
  output logic                 frame_valid,
  output logic                 locked,
  output logic                 sync_err
);

  tdm_state_t state_d, state_q;

  logic [NUM_SLOTS-2:0][W-1:0] shadow_d, shadow_q;
  logic [NUM_SLOTS*W-1:0]      y_d, y_q;
  logic                        frame_valid_d, frame_valid_q;
  logic                        sync_err_d, sync_err_q;

  logic [SLOT_W-1:0] cnt;
  logic              cnt_last;
  logic              cnt_inc;
  logic              cnt_load;
  logic              misplaced;

  tdm_slot_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_inc),
    .load1 (cnt_load),
    .count (cnt),
    .last  (cnt_last)
  );

  always_comb begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    misplaced = en && sync && (cnt != '0);
`else
    misplaced = 1'b0;
`endif
  end

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    y_d           = y_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    cnt_inc       = 1'b0;
    cnt_load      = 1'b0;

    case (state_q)
      HUNT: begin
        if (en && sync) begin
          shadow_d[0] = din;
          cnt_load    = 1'b1;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        if (misplaced) begin
          // Realign on the stray sync: the partial frame is dropped, this slot becomes slot 0.
          sync_err_d  = 1'b1;
          shadow_d    = '0;
          shadow_d[0] = din;
          cnt_load    = 1'b1;
        end else if (en) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            y_d           = {din, shadow_q};
            frame_valid_d = 1'b1;
          end else begin
            case (cnt)
              SLOT_W'(0): shadow_d[0] = din;
              SLOT_W'(1): shadow_d[1] = din;
              SLOT_W'(2): shadow_d[2] = din;
              default:    ;
            endcase
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      shadow_q      <= '0;
      y_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign Y           = y_q;
  assign frame_valid = frame_valid_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Scoreboard bench for tdm_demux_1_4 (W=1 and W=8 instances); honours TDM_DEMUX_SYNC_CHECK_EN.
module tb_tdm_demux_1_4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en, sync;
  logic [0:0] din;
  logic [3:0] y;
  logic       fv, locked, sync_err;

  logic       en8, sync8;
  logic [7:0] din8;
  logic [31:0] y8;
  logic       fv8, locked8, sync_err8;

  tdm_demux_1_4 #(.W(1)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .din(din),
    .Y(y), .frame_valid(fv), .locked(locked), .sync_err(sync_err)
  );

  tdm_demux_1_4 #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .sync(sync8), .din(din8),
    .Y(y8), .frame_valid(fv8), .locked(locked8), .sync_err(sync_err8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp8_q[$];
  int fv_cyc[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected frame whenever the DUT presents one.
  always @(negedge clk) begin
    if (!rst) begin
      if (fv) begin
        fv_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_frame_valid", {28'd0, y}, 32'hFFFF_FFFF);
        else check("Y_w1", {28'd0, y}, exp_q.pop_front());
      end
      if (fv8) begin
        if (exp8_q.size() == 0) check("unexpected_frame_valid_w8", y8, 32'hFFFF_FFFF);
        else check("Y_w8", y8, exp8_q.pop_front());
      end
      if (sync_err) err_cnt++;
    end
  end

  task automatic slot(input logic e, input logic s, input logic d);
    en = e; sync = s; din = d;
    @(posedge clk); #1;
    en = 1'b0; sync = 1'b0;
  endtask

  task automatic slot8(input logic s, input logic [7:0] d);
    en8 = 1'b1; sync8 = s; din8 = d;
    @(posedge clk); #1;
    en8 = 1'b0; sync8 = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;
    en8 = 1'b0; sync8 = 1'b0; din8 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_Y", {28'd0, y}, 32'd0);
    check("reset_frame_valid", {31'd0, fv}, 32'd0);
    check("reset_locked", {31'd0, locked}, 32'd0);
    check("reset_sync_err", {31'd0, sync_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single frame 0,1,0,1
    slot(1, 1, 0);
    check("locked_after_sync", {31'd0, locked}, 32'd1);
    slot(1, 0, 1);
    slot(1, 0, 0);
    exp_q.push_back(32'hA);
    slot(1, 0, 1);
    check("frame_valid_after_slot3", {31'd0, fv}, 32'd1);
    slot(0, 0, 0);
    check("frame_valid_single_pulse", {31'd0, fv}, 32'd0);

    // Back-to-back frames, sync only on the first
    base = fv_cyc.size();
    slot(1, 1, 0); slot(1, 0, 1); slot(1, 0, 0);
    exp_q.push_back(32'hA);
    slot(1, 0, 1);
    slot(1, 0, 1); slot(1, 0, 1); slot(1, 0, 0);
    exp_q.push_back(32'h3);
    slot(1, 0, 0);
    @(negedge clk); #1;
    check("b2b_frame_count", fv_cyc.size() - base, 2);
    if (fv_cyc.size() >= base + 2)
      check("b2b_spacing", fv_cyc[base+1] - fv_cyc[base], 4);

    // Stall in mid-frame
    slot(1, 1, 0); slot(1, 0, 1);
    slot(0, 0, 1); slot(0, 1, 1); slot(0, 0, 0);
    check("stall_Y_held", {28'd0, y}, 32'h3);
    slot(1, 0, 0);
    exp_q.push_back(32'hA);
    slot(1, 0, 1);
    slot(0, 0, 0);

    // Reset mid-frame with Y=1010 held
    slot(1, 1, 1); slot(1, 0, 1);
    rst = 1'b1;
    #1;
    check("midreset_Y", {28'd0, y}, 32'd0);
    check("midreset_locked", {31'd0, locked}, 32'd0);
    check("midreset_frame_valid", {31'd0, fv}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    slot(1, 0, 1); slot(1, 0, 0); slot(1, 0, 1);
    check("hunt_without_sync", {31'd0, locked}, 32'd0);
    slot(1, 1, 1); slot(1, 0, 0); slot(1, 0, 0);
    exp_q.push_back(32'h9);
    slot(1, 0, 1);
    slot(0, 0, 0);

    // Misplaced sync at slot 2 with din=1, then 0,1,1
    slot(1, 1, 1); slot(1, 0, 0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    slot(1, 1, 1);
    check("sync_err_pulse", {31'd0, sync_err}, 32'd1);
    slot(1, 0, 0);
    check("sync_err_one_cycle", {31'd0, sync_err}, 32'd0);
    slot(1, 0, 1);
    exp_q.push_back(32'hD);
    slot(1, 0, 1);
    check("locked_after_realign", {31'd0, locked}, 32'd1);
    slot(0, 0, 0);
    check("sync_err_count", err_cnt, 1);
`else
    slot(1, 1, 1);
    check("sync_err_tied_low", {31'd0, sync_err}, 32'd0);
    exp_q.push_back(32'h5);
    slot(1, 0, 0);
    slot(1, 0, 1); slot(1, 0, 1);
    slot(0, 0, 0);
    check("sync_err_count", err_cnt, 0);
`endif

    // W=8 frame
    slot8(1, 8'hA1); slot8(0, 8'hB2); slot8(0, 8'hC3);
    exp8_q.push_back(32'hD4C3_B2A1);
    slot8(0, 8'hD4);
    check("w8_locked", {31'd0, locked8}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("w1_scoreboard_drained", exp_q.size(), 0);
    check("w8_scoreboard_drained", exp8_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
